// File: rtl/trigger_input_conditioner_if.sv
// Log readout port of the trigger input conditioner: FWFT head, pop strobe and status.
interface trigger_input_conditioner_if;
  logic [25:0] log_dout;
  logic        log_rd;
  logic        log_empty;
  logic        log_full;
  logic        overflow;

  // Readout side: pops entries and watches status.
  modport master (
    output log_rd,
    input  log_dout,
    input  log_empty,
    input  log_full,
    input  overflow
  );

  // Conditioner side: owns the log FIFO.
  modport slave (
    input  log_rd,
    output log_dout,
    output log_empty,
    output log_full,
    output overflow
  );
endinterface

// File: rtl/trigger_input_conditioner.sv
// Trigger input conditioner: synchronises and qualifies the external trigger (polarity,
// minimum width, holdoff, busy/enable veto), issues a 1-cycle trigger pulse, logs each
// accepted trigger {index, timestamp} into a FWFT FIFO and keeps saturating counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARMED    | idle, waiting for the conditioned input to go active
// MEASURE  | input active, counting width up to minwidth
// HOLDOFF  | dead time after an accepted trigger; new rising edges vetoed
// WAIT_LOW | waiting for the input to return inactive before re-arming
module trigger_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trig_ext,
  input  logic        invert,
  input  logic        enable,
  input  logic [7:0]  minwidth,
  input  logic [15:0] holdoff,
  input  logic        busy,
  input  logic [9:0]  timestamp,
  input  logic        clear,
  output logic        trigger,
  output logic [15:0] trigcount,
  output logic [15:0] vetocount,
  output logic [15:0] glitchcount,
  trigger_input_conditioner_if.slave log
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ARMED, MEASURE, HOLDOFF, WAIT_LOW} state_t;

  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic        s_in, s_prev;
  logic [7:0]  wcnt, wcnt_d;
  logic [15:0] hcnt, hcnt_d;
  logic        qualify, vetoed, accept, glitch, holdoff_veto;

  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count;
  logic [25:0]   dout_q, push_data, head_next;
  logic          overflow_q, full, empty, push, pop, push_ok;

  assign s_in = sync_q[SYNC_STAGES-1] ^ invert;

  // Synchroniser chain on the asynchronous trigger plus one-cycle history for edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_ext};
      s_prev <= s_in;
    end
  end

  // FSM state and width/holdoff timers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ARMED;
      wcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
      hcnt  <= hcnt_d;
    end
  end

  // Next-state decode; holdoff runs as a down-counter loaded on accept, leaving at zero.
  always_comb begin
    state_d      = state;
    wcnt_d       = wcnt;
    hcnt_d       = hcnt;
    qualify      = 1'b0;
    glitch       = 1'b0;
    holdoff_veto = 1'b0;
    case (state)
      ARMED: begin
        if (s_in) begin
          if (minwidth <= 8'd1) begin
            qualify = 1'b1;
          end else begin
            state_d = MEASURE;
            wcnt_d  = 8'd1;
          end
        end
      end
      MEASURE: begin
        if (!s_in) begin
          glitch  = 1'b1;
          state_d = ARMED;
        end else begin
          wcnt_d = wcnt + 8'd1;
          if (({1'b0, wcnt} + 9'd1) >= {1'b0, minwidth}) qualify = 1'b1;
        end
      end
      HOLDOFF: begin
        holdoff_veto = s_in & ~s_prev;
        if (hcnt == 16'd0) state_d = WAIT_LOW;
        else               hcnt_d  = hcnt - 16'd1;
      end
      WAIT_LOW: begin
        if (!s_in) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
    vetoed = qualify & (busy | ~enable);
    accept = qualify & ~vetoed;
    if (vetoed) state_d = WAIT_LOW;
    if (accept) begin
      state_d = HOLDOFF;
      hcnt_d  = holdoff;
    end
  end

  // Trigger pulse and saturating event counters; clear leaves the pulse alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trigger     <= 1'b0;
      trigcount   <= '0;
      vetocount   <= '0;
      glitchcount <= '0;
    end else begin
      trigger <= accept;
      if (clear) begin
        trigcount   <= '0;
        vetocount   <= '0;
        glitchcount <= '0;
      end else begin
        if (accept && trigcount != 16'hFFFF)                     trigcount   <= trigcount + 16'd1;
        if ((vetoed || holdoff_veto) && vetocount != 16'hFFFF)    vetocount   <= vetocount + 16'd1;
        if (glitch && glitchcount != 16'hFFFF)                    glitchcount <= glitchcount + 16'd1;
      end
    end
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push_data = {trigcount, timestamp};
  assign push      = accept & ~clear;
  assign pop       = log.log_rd & ~empty & ~clear;
  assign push_ok   = push & (~full | pop);
  assign rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;
  // The head after this edge is the entry being written when it lands on the new read slot.
  assign head_next = (push_ok && wr_ptr == rd_next) ? push_data : mem[rd_next];

  // Log storage; contents need no reset since count gates validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      dout_q <= head_next;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign log.log_dout  = dout_q;
  assign log.log_empty = empty;
  assign log.log_full  = full;
  assign log.overflow  = overflow_q;

endmodule

// File: tb/tb_trigger_input_conditioner.sv
// Directed bench for trigger_input_conditioner with hand-computed expectations.
module tb_trigger_input_conditioner;
  logic        clock = 1'b0;
  logic        reset;
  logic        trig_ext, invert, enable, busy, clear;
  logic [7:0]  minwidth;
  logic [15:0] holdoff;
  logic [9:0]  timestamp;
  logic        trigger;
  logic [15:0] trigcount, vetocount, glitchcount;

  int nvec = 0;
  int nerr = 0;

  trigger_input_conditioner_if log_if ();

  trigger_input_conditioner #(.SYNC_STAGES(2), .FIFO_DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .trig_ext    (trig_ext),
    .invert      (invert),
    .enable      (enable),
    .minwidth    (minwidth),
    .holdoff     (holdoff),
    .busy        (busy),
    .timestamp   (timestamp),
    .clear       (clear),
    .trigger     (trigger),
    .trigcount   (trigcount),
    .vetocount   (vetocount),
    .glitchcount (glitchcount),
    .log         (log_if)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; timestamp free-runs one count per cycle.
  task automatic tick();
    @(negedge clock);
    timestamp = timestamp + 10'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pop();
    log_if.log_rd = 1'b1;
    tick();
    log_if.log_rd = 1'b0;
  endtask

  // Raise trig_ext now (at a falling edge), hold for hi cycles, observe for total cycles.
  task automatic run_pulse(input int hi, input int total, output int npulse,
                           output int first_k, output logic [9:0] ts0);
    npulse  = 0;
    first_k = -1;
    ts0     = timestamp;
    trig_ext = 1'b1;
    for (int k = 1; k <= total; k++) begin
      tick();
      if (k == hi) trig_ext = 1'b0;
      if (trigger) begin
        npulse++;
        if (first_k < 0) first_k = k;
      end
    end
  endtask

  int          np, fk, np2, fk2, total;
  logic [9:0]  ts0, ts1;
  logic [9:0]  exp_ts [9];

  initial begin
    reset = 1'b1; trig_ext = 1'b0; invert = 1'b0; enable = 1'b1; busy = 1'b0;
    clear = 1'b0; minwidth = 8'd4; holdoff = 16'd10; timestamp = 10'd100;
    log_if.log_rd = 1'b0;
    ticks(3);
    chk("rst_trigger",   32'(trigger), 32'd0);
    chk("rst_trigcount", 32'(trigcount), 32'd0);
    chk("rst_empty",     32'(log_if.log_empty), 32'd1);
    chk("rst_full_ovf",  {30'd0, log_if.log_full, log_if.overflow}, 32'd0);
    chk("rst_dout",      32'(log_if.log_dout), 32'd0);
    reset = 1'b0;
    ticks(3);

    // minwidth=4, 6-cycle pulse: accepted at SYNC_STAGES+4 = 6 clocks
    run_pulse(6, 8, np, fk, ts0);
    chk("acc_npulse",    32'(np), 32'd1);
    chk("acc_latency",   32'(fk), 32'd6);
    chk("acc_trigcount", 32'(trigcount), 32'd1);
    chk("acc_empty",     32'(log_if.log_empty), 32'd0);
    chk("acc_log",       32'(log_if.log_dout), 32'({16'd0, 10'(ts0 + 10'd5)}));
    ticks(14);
    pop();
    chk("acc_pop_empty", 32'(log_if.log_empty), 32'd1);

    // minwidth=4, 2-cycle pulse: glitch
    run_pulse(2, 10, np, fk, ts0);
    chk("glitch_npulse", 32'(np), 32'd0);
    chk("glitch_count",  32'(glitchcount), 32'd1);
    chk("glitch_state",  32'(dut.state), 32'd0);

    // clear, then busy veto and enable veto
    do_clear();
    chk("clear_counts",  {trigcount, glitchcount | vetocount}, 32'd0);
    busy = 1'b1;
    run_pulse(6, 12, np, fk, ts0);
    busy = 1'b0;
    chk("busy_npulse",   32'(np), 32'd0);
    chk("busy_veto",     32'(vetocount), 32'd1);
    enable = 1'b0;
    run_pulse(6, 12, np, fk, ts0);
    enable = 1'b1;
    chk("en_npulse",     32'(np), 32'd0);
    chk("en_veto",       32'(vetocount), 32'd2);
    chk("veto_trigcnt",  32'(trigcount), 32'd0);
    chk("veto_empty",    32'(log_if.log_empty), 32'd1);

    // holdoff=100, second rising edge 30 cycles after the first
    do_clear();
    holdoff = 16'd100;
    run_pulse(6, 30, np, fk, ts0);
    run_pulse(6, 20, np2, fk2, ts1);
    chk("ho_npulse1",    32'(np), 32'd1);
    chk("ho_npulse2",    32'(np2), 32'd0);
    chk("ho_veto",       32'(vetocount), 32'd1);
    chk("ho_trigcount",  32'(trigcount), 32'd1);
    chk("ho_log",        32'(log_if.log_dout), 32'({16'd0, 10'(ts0 + 10'd5)}));
    ticks(70);

    // FIFO fill: minwidth=1, holdoff=0, 9 accepted triggers without reads
    do_clear();
    minwidth = 8'd1;
    holdoff  = 16'd0;
    total    = 0;
    for (int i = 0; i < 9; i++) begin
      run_pulse(2, 6, np, fk, ts0);
      total += np;
      exp_ts[i] = ts0 + 10'd2;
      chk("fifo_latency", 32'(fk), 32'd3);
    end
    chk("fifo_pulses",   32'(total), 32'd9);
    chk("fifo_full",     32'(log_if.log_full), 32'd1);
    chk("fifo_ovf",      32'(log_if.overflow), 32'd1);
    chk("fifo_trigcnt",  32'(trigcount), 32'd9);
    for (int i = 0; i < 8; i++) begin
      chk("fifo_entry", 32'(log_if.log_dout), 32'({16'(i), exp_ts[i]}));
      pop();
    end
    chk("fifo_drained",  32'(log_if.log_empty), 32'd1);
    chk("fifo_ovf_stk",  32'(log_if.overflow), 32'd1);
    do_clear();
    chk("clear_ovf",     32'(log_if.overflow), 32'd0);

    // reset in HOLDOFF with 3 entries, trigger pulse in flight; minwidth=0
    minwidth = 8'd0;
    run_pulse(2, 6, np, fk, ts0);
    run_pulse(2, 6, np, fk, ts0);
    holdoff = 16'd100;
    run_pulse(2, 3, np, fk, ts0);
    chk("pre_rst_trig",  32'(trigger), 32'd1);
    chk("pre_rst_cnt",   32'(trigcount), 32'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_trig",  32'(trigger), 32'd0);
    chk("mid_rst_cnt",   32'(trigcount), 32'd0);
    chk("mid_rst_empty", 32'(log_if.log_empty), 32'd1);
    chk("mid_rst_dout",  32'(log_if.log_dout), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'd0);
    ticks(2);
    reset = 1'b0;
    tick();
    run_pulse(2, 8, np, fk, ts0);
    chk("post_rst_np",   32'(np), 32'd1);
    chk("post_rst_lat",  32'(fk), 32'd3);
    chk("post_rst_cnt",  32'(trigcount), 32'd1);
    chk("post_rst_log",  32'(log_if.log_dout), 32'({16'd0, 10'(ts0 + 10'd2)}));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
